// File: rtl/accelerator_dnc_pkg.sv
// Shared types and constants for the DNC memory datapath blocks.
// Holds the scalar-unit arbiter FSM encoding and common control words.
package accelerator_dnc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  localparam logic [63:0] ZERO_DATA    = 64'd0;
  localparam logic [63:0] ZERO_CONTROL = 64'd0;
  localparam logic [63:0] ONE_CONTROL  = 64'd1;

endpackage

// File: rtl/accelerator_round_robin_picker.sv
// Combinational round-robin selector: first set request at or above ptr_i,
// wrapping. Ports: req_i (requests), ptr_i (start index), valid_o, idx_o.
module accelerator_round_robin_picker
  import accelerator_dnc_pkg::*;
#(
  parameter int REQUESTERS = 4,
  parameter int IDX_W      = $clog2(REQUESTERS)
) (
  input  logic [REQUESTERS-1:0] req_i,
  input  logic [IDX_W-1:0]      ptr_i,
  output logic                  valid_o,
  output logic [IDX_W-1:0]      idx_o
);

  int c;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    c       = 0;
    for (int k = REQUESTERS - 1; k >= 0; k--) begin
      c = int'(ptr_i) + k;
      if (c >= REQUESTERS) c = c - REQUESTERS;
      if (req_i[c]) begin
        valid_o = 1'b1;
        idx_o   = c[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/accelerator_scalar_float_arbiter.sv
// Round-robin arbiter sharing one scalar FP unit among START/READY requesters.
// Ports: per-requester START/OPERATION/DATA_A/DATA_B in, READY_OUT/DATA_OUT
// out; GRANT/BUSY status; UNIT_* drives and observes the shared unit.
module accelerator_scalar_float_arbiter
  import accelerator_dnc_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int REQUESTERS   = 4
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [REQUESTERS-1:0]           START_IN,
  input  logic [REQUESTERS-1:0]           OPERATION_IN,
  input  logic [REQUESTERS*DATA_SIZE-1:0] DATA_A_IN,
  input  logic [REQUESTERS*DATA_SIZE-1:0] DATA_B_IN,
  output logic [REQUESTERS-1:0]           READY_OUT,
  output logic [DATA_SIZE-1:0]            DATA_OUT,
  output logic [$clog2(REQUESTERS)-1:0]   GRANT,
  output logic                            BUSY,
  output logic                            UNIT_START,
  input  logic                            UNIT_READY,
  output logic                            UNIT_OPERATION,
  output logic [DATA_SIZE-1:0]            UNIT_DATA_A,
  output logic [DATA_SIZE-1:0]            UNIT_DATA_B,
  input  logic [DATA_SIZE-1:0]            UNIT_DATA_OUT
);

  localparam int IDX_W = $clog2(REQUESTERS);

  if (REQUESTERS < 2 || REQUESTERS > 16 || CONTROL_SIZE < 1) begin : g_bad_cfg
    $error("accelerator_scalar_float_arbiter: bad parameters");
  end

  arb_state_e            state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic                  busy_q, busy_d;
  logic                  ustart_q, ustart_d;
  logic                  uop_q, uop_d;
  logic [DATA_SIZE-1:0]  ua_q, ua_d;
  logic [DATA_SIZE-1:0]  ub_q, ub_d;
  logic [REQUESTERS-1:0] ready_q, ready_d;
  logic [DATA_SIZE-1:0]  dout_q, dout_d;

  logic                  pick_valid;
  logic [IDX_W-1:0]      pick_idx;

  accelerator_round_robin_picker #(
    .REQUESTERS(REQUESTERS),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req_i  (START_IN),
    .ptr_i  (ptr_q),
    .valid_o(pick_valid),
    .idx_o  (pick_idx)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      ustart_q <= 1'b0;
      uop_q    <= 1'b0;
      ua_q     <= DATA_SIZE'(ZERO_DATA);
      ub_q     <= DATA_SIZE'(ZERO_DATA);
      ready_q  <= '0;
      dout_q   <= DATA_SIZE'(ZERO_DATA);
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      ustart_q <= ustart_d;
      uop_q    <= uop_d;
      ua_q     <= ua_d;
      ub_q     <= ub_d;
      ready_q  <= ready_d;
      dout_q   <= dout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    busy_d   = busy_q;
    ustart_d = ustart_q;
    uop_d    = uop_q;
    ua_d     = ua_q;
    ub_d     = ub_q;
    ready_d  = ready_q;
    dout_d   = dout_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d  = pick_idx;
          busy_d   = 1'b1;
          ustart_d = 1'b1;
          uop_d    = OPERATION_IN[pick_idx];
          ua_d     = DATA_A_IN[pick_idx*DATA_SIZE +: DATA_SIZE];
          ub_d     = DATA_B_IN[pick_idx*DATA_SIZE +: DATA_SIZE];
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        ustart_d = 1'b0;
        if (UNIT_READY) begin
          dout_d  = UNIT_DATA_OUT;
          ready_d = {{(REQUESTERS-1){1'b0}}, 1'b1} << grant_q;
          // Advance past the grantee so it cannot win twice in a row.
          if (grant_q == IDX_W'(REQUESTERS - 1)) ptr_d = '0;
          else ptr_d = grant_q + 1'b1;
          state_d = ST_RELEASE;
        end
      end
      // One dead cycle lets the grantee drop START_IN before re-arbitration.
      ST_RELEASE: begin
        ready_d = '0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign READY_OUT      = ready_q;
  assign DATA_OUT       = dout_q;
  assign GRANT          = grant_q;
  assign BUSY           = busy_q;
  assign UNIT_START     = ustart_q;
  assign UNIT_OPERATION = uop_q;
  assign UNIT_DATA_A    = ua_q;
  assign UNIT_DATA_B    = ub_q;

endmodule

// File: tb/tb_accelerator_scalar_float_arbiter.sv
// Bench for accelerator_scalar_float_arbiter with an adder-like unit model
// (result A+B, ready 3 cycles after start) and a result scoreboard.
module tb_accelerator_scalar_float_arbiter;

  localparam int DW = 64;
  localparam int R  = 4;

  logic            CLK;
  logic            RST;
  logic [R-1:0]    START_IN;
  logic [R-1:0]    OPERATION_IN;
  logic [R*DW-1:0] DATA_A_IN;
  logic [R*DW-1:0] DATA_B_IN;
  logic [R-1:0]    READY_OUT;
  logic [DW-1:0]   DATA_OUT;
  logic [1:0]      GRANT;
  logic            BUSY;
  logic            UNIT_START;
  logic            UNIT_READY;
  logic            UNIT_OPERATION;
  logic [DW-1:0]   UNIT_DATA_A;
  logic [DW-1:0]   UNIT_DATA_B;
  logic [DW-1:0]   UNIT_DATA_OUT;

  logic          model_ready, spur_ready;
  logic [DW-1:0] model_data, spur_data;

  assign UNIT_READY    = model_ready | spur_ready;
  assign UNIT_DATA_OUT = spur_ready ? spur_data : model_data;

  accelerator_scalar_float_arbiter #(
    .DATA_SIZE   (DW),
    .CONTROL_SIZE(64),
    .REQUESTERS  (R)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .START_IN      (START_IN),
    .OPERATION_IN  (OPERATION_IN),
    .DATA_A_IN     (DATA_A_IN),
    .DATA_B_IN     (DATA_B_IN),
    .READY_OUT     (READY_OUT),
    .DATA_OUT      (DATA_OUT),
    .GRANT         (GRANT),
    .BUSY          (BUSY),
    .UNIT_START    (UNIT_START),
    .UNIT_READY    (UNIT_READY),
    .UNIT_OPERATION(UNIT_OPERATION),
    .UNIT_DATA_A   (UNIT_DATA_A),
    .UNIT_DATA_B   (UNIT_DATA_B),
    .UNIT_DATA_OUT (UNIT_DATA_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   stamp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_ops(int i, logic [DW-1:0] a, logic [DW-1:0] b);
    DATA_A_IN[i*DW +: DW] = a;
    DATA_B_IN[i*DW +: DW] = b;
  endtask

  task automatic push(int i, logic [DW-1:0] d);
    exp_t e;
    e.idx  = i;
    e.data = d;
    sb_q.push_back(e);
  endtask

  // Called at a negedge where READY_OUT is nonzero.
  task automatic expect_pulse(bit drop);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_unexpected", 64'(READY_OUT), 64'd0);
    end else begin
      e = sb_q.pop_front();
      chk("ready_out", 64'(READY_OUT), 64'd1 << e.idx);
      chk("data_out", DATA_OUT, e.data);
    end
    stamp_q.push_back(cyc);
    if (drop) START_IN = START_IN & ~READY_OUT;
  endtask

  task automatic wait_results(int n, bit drop, int budget);
    int got;
    int c;
    got = 0;
    c   = 0;
    while (got < n && c < budget) begin
      @(negedge CLK);
      c++;
      if (READY_OUT != '0) begin
        expect_pulse(drop);
        got++;
      end
    end
    if (got < n) chk("timeout", 64'(got), 64'(n));
  endtask

  // Unit model: result A+B, ready sampled on the 4th edge after start rises.
  initial begin
    bit            abort;
    logic [DW-1:0] a, b;
    model_ready = 1'b0;
    model_data  = '0;
    forever begin
      @(negedge CLK);
      if (UNIT_START === 1'b1 && !RST) begin
        a     = UNIT_DATA_A;
        b     = UNIT_DATA_B;
        abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge CLK);
          if (RST) abort = 1'b1;
        end
        if (!abort) begin
          model_ready = 1'b1;
          model_data  = a + b;
          @(negedge CLK);
          model_ready = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST          = 1'b1;
    START_IN     = '0;
    OPERATION_IN = '0;
    DATA_A_IN    = '0;
    DATA_B_IN    = '0;
    spur_ready   = 1'b0;
    spur_data    = '0;

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_ready", 64'(READY_OUT), 64'd0);
    chk("rst_dout", DATA_OUT, 64'd0);
    chk("rst_grant", 64'(GRANT), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_ustart", 64'(UNIT_START), 64'd0);
    chk("rst_uop", 64'(UNIT_OPERATION), 64'd0);
    chk("rst_ua", UNIT_DATA_A, 64'd0);
    chk("rst_ub", UNIT_DATA_B, 64'd0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Single request, latency and BUSY fall
    set_ops(0, 64'd5, 64'd7);
    START_IN = 4'b0001;
    push(0, 64'd12);
    @(negedge CLK);
    chk("t1_ustart", 64'(UNIT_START), 64'd1);
    chk("t1_busy", 64'(BUSY), 64'd1);
    chk("t1_grant", 64'(GRANT), 64'd0);
    chk("t1_ua", UNIT_DATA_A, 64'd5);
    chk("t1_ub", UNIT_DATA_B, 64'd7);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("t1_no_early", 64'(READY_OUT), 64'd0);
      chk("t1_ustart_low", 64'(UNIT_START), 64'd0);
    end
    wait_results(1, 1'b1, 1);
    chk("t1_busy_pulse", 64'(BUSY), 64'd1);
    @(negedge CLK);
    chk("t1_busy_fall", 64'(BUSY), 64'd0);
    chk("t1_ready_fall", 64'(READY_OUT), 64'd0);
    chk("t1_dout_held", DATA_OUT, 64'd12);

    // Pointer to 2 via requester 1, then 0001|1000 serves 3 before 0
    set_ops(1, 64'd3, 64'd4);
    START_IN = 4'b0010;
    push(1, 64'd7);
    wait_results(1, 1'b1, 20);
    @(negedge CLK);
    set_ops(3, 64'd30, 64'd1);
    set_ops(0, 64'd40, 64'd2);
    START_IN = 4'b1001;
    push(3, 64'd31);
    push(0, 64'd42);
    @(negedge CLK);
    chk("t3_first_grant", 64'(GRANT), 64'd3);
    wait_results(2, 1'b1, 40);
    @(negedge CLK);

    // Reset during WAIT, then fresh request from requester 2
    set_ops(1, 64'd8, 64'd9);
    OPERATION_IN = 4'b0010;
    START_IN     = 4'b0010;
    @(negedge CLK);
    chk("t6_grant", 64'(GRANT), 64'd1);
    chk("t6_uop", 64'(UNIT_OPERATION), 64'd1);
    @(negedge CLK);
    #2;
    RST      = 1'b1;
    START_IN = '0;
    #1;
    chk("t6_rst_grant", 64'(GRANT), 64'd0);
    chk("t6_rst_busy", 64'(BUSY), 64'd0);
    chk("t6_rst_dout", DATA_OUT, 64'd0);
    chk("t6_rst_uop", 64'(UNIT_OPERATION), 64'd0);
    chk("t6_rst_ua", UNIT_DATA_A, 64'd0);
    chk("t6_rst_ub", UNIT_DATA_B, 64'd0);
    repeat (4) @(negedge CLK);
    RST          = 1'b0;
    OPERATION_IN = '0;
    set_ops(2, 64'd20, 64'd22);
    START_IN = 4'b0100;
    push(2, 64'd42);
    @(negedge CLK);
    chk("t6_new_grant", 64'(GRANT), 64'd2);
    chk("t6_new_ustart", 64'(UNIT_START), 64'd1);
    wait_results(1, 1'b1, 20);
    repeat (2) @(negedge CLK);

    // Spurious UNIT_READY while idle
    spur_data  = 64'd777;
    spur_ready = 1'b1;
    @(negedge CLK);
    spur_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("t5_no_ready", 64'(READY_OUT), 64'd0);
      chk("t5_dout_held", DATA_OUT, 64'd42);
      chk("t5_busy", 64'(BUSY), 64'd0);
      @(negedge CLK);
    end

    // Fairness from pointer 0 with all requests held
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < R; i++) begin
      set_ops(i, 64'(i), 64'd10);
      push(i, 64'(i + 10));
    end
    push(0, 64'd10);
    stamp_q.delete();
    START_IN = 4'b1111;
    wait_results(5, 1'b0, 80);
    START_IN = '0;
    for (int i = 1; i < stamp_q.size(); i++)
      chk("rr_period", 64'(stamp_q[i] - stamp_q[i-1]), 64'd6);
    @(negedge CLK);

    // Late request from requester 1 during requester 0's WAIT
    set_ops(0, 64'd50, 64'd5);
    set_ops(1, 64'd99, 64'd1);
    START_IN = 4'b0001;
    push(0, 64'd55);
    push(1, 64'd100);
    @(negedge CLK);
    chk("t4_grant0", 64'(GRANT), 64'd0);
    chk("t4_ua0", UNIT_DATA_A, 64'd50);
    @(negedge CLK);
    START_IN[1] = 1'b1;
    @(negedge CLK);
    chk("t4_ua_stable", UNIT_DATA_A, 64'd50);
    chk("t4_ub_stable", UNIT_DATA_B, 64'd5);
    chk("t4_grant_stable", 64'(GRANT), 64'd0);
    wait_results(1, 1'b1, 20);
    @(negedge CLK);
    chk("t4_release_ustart", 64'(UNIT_START), 64'd0);
    chk("t4_release_grant", 64'(GRANT), 64'd0);
    @(negedge CLK);
    chk("t4_grant1", 64'(GRANT), 64'd1);
    chk("t4_ustart1", 64'(UNIT_START), 64'd1);
    chk("t4_ua1", UNIT_DATA_A, 64'd99);
    wait_results(1, 1'b1, 20);

    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
